// File: rtl/horizontal_rom_bank_writer.sv
// horizontal_rom_bank_writer
//   Captures the eight steered lanes (ROM0..ROM7) into 15 segmented banks:
//   ROM0 has a single segment, ROM1..ROM7 each have segments A and B.
//   Each segment fills sequentially through its own write pointer.
//   A registered random-access read port feeds the next NTT stage.
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   clr                 sync clear of pointers/full/load_done/wr_err (memory kept)
//   rom0_in..rom7_in    lane data
//   rom0_w              1 = write ROM0 segment
//   rom1_w..rom7_w      0 none, 1 seg A, 2 seg B, 3 illegal
//   rd_en/rd_rom/rd_seg/rd_addr   read request (rd_seg ignored for ROM0)
//   rd_data/rd_valid    registered read result, latency 1
//   load_done           all 15 segments full (registered level)
//   wr_err              sticky: illegal code or write into a full segment
module horizontal_rom_bank_writer #(
    parameter int P_WIDTH   = 64,
    parameter int SEG_DEPTH = 16,
    parameter int SEG_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [P_WIDTH-1:0] rom0_in,
    input  logic [P_WIDTH-1:0] rom1_in,
    input  logic [P_WIDTH-1:0] rom2_in,
    input  logic [P_WIDTH-1:0] rom3_in,
    input  logic [P_WIDTH-1:0] rom4_in,
    input  logic [P_WIDTH-1:0] rom5_in,
    input  logic [P_WIDTH-1:0] rom6_in,
    input  logic [P_WIDTH-1:0] rom7_in,
    input  logic               rom0_w,
    input  logic [1:0]         rom1_w,
    input  logic [1:0]         rom2_w,
    input  logic [1:0]         rom3_w,
    input  logic [1:0]         rom4_w,
    input  logic [1:0]         rom5_w,
    input  logic [1:0]         rom6_w,
    input  logic [1:0]         rom7_w,
    input  logic               rd_en,
    input  logic [2:0]         rd_rom,
    input  logic               rd_seg,
    input  logic [SEG_AW-1:0]  rd_addr,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               load_done,
    output logic               wr_err
);
    localparam int NUM_ROMS = 8;
    localparam int NUM_SEGS = 15;

    logic [NUM_ROMS-1:0][P_WIDTH-1:0] din;
    logic [NUM_ROMS-1:0][1:0]         code;
    logic [NUM_SEGS-1:0]              full;
    logic [NUM_SEGS-1:0]              seg_we;
    logic [NUM_SEGS-1:0][P_WIDTH-1:0] seg_rd;
    logic [NUM_ROMS-1:0]              rom_err;
    logic [3:0]                       rd_sel;

    assign din  = {rom7_in, rom6_in, rom5_in, rom4_in, rom3_in, rom2_in, rom1_in, rom0_in};
    // ROM0's single-bit strobe is widened so it reads as "code 1 = segment 0".
    assign code = {rom7_w, rom6_w, rom5_w, rom4_w, rom3_w, rom2_w, rom1_w, {1'b0, rom0_w}};

    // Segment numbering: 0 = ROM0, 2k-1 = ROMk.A, 2k = ROMk.B.
    for (genvar i = 0; i < NUM_SEGS; i++) begin : g_seg
        localparam int         ROM  = (i + 1) / 2;
        localparam logic [1:0] CODE = (i == 0 || (i % 2) == 1) ? 2'd1 : 2'd2;

        logic [SEG_AW-1:0]  wptr;
        logic               full_q;
        logic [P_WIDTH-1:0] mem [SEG_DEPTH];

        // clr wins over any write in the same cycle.
        assign seg_we[i] = !clr && (code[ROM] == CODE) && !full_q;
        assign full[i]   = full_q;
        assign seg_rd[i] = mem[rd_addr];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr   <= '0;
                full_q <= 1'b0;
            end else if (clr) begin
                wptr   <= '0;
                full_q <= 1'b0;
            end else if (seg_we[i]) begin
                wptr <= wptr + 1'b1;  // wraps to 0 on the last entry
                if (wptr == SEG_AW'(SEG_DEPTH - 1))
                    full_q <= 1'b1;
            end
        end

        // Storage is not reset; stale data is simply overwritten on refill.
        always_ff @(posedge clk) begin
            if (seg_we[i])
                mem[wptr] <= din[ROM];
        end
    end

    for (genvar r = 0; r < NUM_ROMS; r++) begin : g_err
        if (r == 0) begin : g_rom0
            assign rom_err[r] = (code[r] == 2'd1) && full[0];
        end else begin : g_romk
            assign rom_err[r] = (code[r] == 2'd3)
                              || ((code[r] == 2'd1) && full[2*r-1])
                              || ((code[r] == 2'd2) && full[2*r]);
        end
    end

    always_comb begin
        rd_sel = 4'd0;
        if (rd_rom != 3'd0)
            rd_sel = {rd_rom, 1'b0} - 4'd1 + {3'd0, rd_seg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            load_done <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            // Memory writes are non-blocking too, so a same-entry collision reads old data.
            if (rd_en)
                rd_data <= seg_rd[rd_sel];
            if (clr) begin
                load_done <= 1'b0;
                wr_err    <= 1'b0;
            end else begin
                load_done <= &full;
                if (|rom_err)
                    wr_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_horizontal_rom_bank_writer.sv
module tb_horizontal_rom_bank_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [63:0] din [8];
    logic [1:0]  wc  [8];
    logic        rd_en;
    logic [2:0]  rd_rom;
    logic        rd_seg;
    logic [3:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid, load_done, wr_err;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    horizontal_rom_bank_writer #(.P_WIDTH(64), .SEG_DEPTH(16), .SEG_AW(4)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .rom0_in(din[0]), .rom1_in(din[1]), .rom2_in(din[2]), .rom3_in(din[3]),
        .rom4_in(din[4]), .rom5_in(din[5]), .rom6_in(din[6]), .rom7_in(din[7]),
        .rom0_w(wc[0][0]), .rom1_w(wc[1]), .rom2_w(wc[2]), .rom3_w(wc[3]),
        .rom4_w(wc[4]), .rom5_w(wc[5]), .rom6_w(wc[6]), .rom7_w(wc[7]),
        .rd_en(rd_en), .rd_rom(rd_rom), .rd_seg(rd_seg), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .load_done(load_done), .wr_err(wr_err)
    );

    function automatic logic [63:0] tag(input int r, input int s, input int i);
        tag = {8'hA5, r[7:0], s[7:0], 8'h00, i[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        else
            n_pass++;
    endtask

    task automatic idle();
        for (int r = 0; r < 8; r++) begin
            wc[r]  = 2'd0;
            din[r] = 64'h0;
        end
        clr   = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream steering pattern: each 16-cycle window writes 4 entries per segment.
    task automatic run_windows(input int nw);
        for (int w = 0; w < nw; w++) begin
            for (int cnt = 0; cnt < 16; cnt++) begin
                int k, idx;
                k   = cnt / 4;
                idx = w * 4 + cnt % 4;
                idle();
                if (k == 0) begin
                    wc[0] = 2'd1; din[0] = tag(0, 0, idx);
                    for (int r = 2; r < 8; r += 2) begin wc[r] = 2'd2; din[r] = tag(r, 1, idx); end
                end else if (k == 1) begin
                    for (int r = 1; r < 8; r += 2) begin wc[r] = 2'd1; din[r] = tag(r, 0, idx); end
                end else if (k == 2) begin
                    for (int r = 1; r < 8; r += 2) begin wc[r] = 2'd2; din[r] = tag(r, 1, idx); end
                end else begin
                    for (int r = 2; r < 8; r += 2) begin wc[r] = 2'd1; din[r] = tag(r, 0, idx); end
                end
                tick();
            end
        end
        idle();
    endtask

    task automatic rd(input int r, input int s, input int a);
        idle();
        rd_en   = 1'b1;
        rd_rom  = r[2:0];
        rd_seg  = s[0];
        rd_addr = a[3:0];
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr1(input int r, input logic [1:0] c, input logic [63:0] v);
        idle();
        wc[r]  = c;
        din[r] = v;
        tick();
        idle();
    endtask

    task automatic read_all(input string nm);
        for (int r = 0; r < 8; r++)
            for (int s = 0; s < ((r == 0) ? 1 : 2); s++)
                for (int a = 0; a < 16; a++) begin
                    rd(r, s, a);
                    chk({nm, "_data"}, rd_data, tag(r, s, a));
                    chk({nm, "_vld"}, {63'h0, rd_valid}, 64'h1);
                end
    endtask

    initial begin
        rd_rom = 3'd0; rd_seg = 1'b0; rd_addr = 4'd0;
        idle();
        rst = 1'b1;
        #1;
        // Reset state
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_valid", {63'h0, rd_valid}, 64'h0);
        chk("rst_load_done", {63'h0, load_done}, 64'h0);
        chk("rst_wr_err", {63'h0, wr_err}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Full upstream sequence
        run_windows(4);
        chk("fill_ld_edge", {63'h0, load_done}, 64'h0);
        tick();
        chk("fill_load_done", {63'h0, load_done}, 64'h1);
        chk("fill_wr_err", {63'h0, wr_err}, 64'h0);
        read_all("fill");
        idle();
        tick();
        chk("rd_idle_vld", {63'h0, rd_valid}, 64'h0);
        chk("rd_idle_hold", rd_data, tag(7, 1, 15));

        // Overfill
        wr1(1, 2'd1, 64'hDEAD_BEEF_0000_0001);
        chk("ovf_wr_err", {63'h0, wr_err}, 64'h1);
        chk("ovf_ld_hold", {63'h0, load_done}, 64'h1);
        rd(1, 0, 0);
        chk("ovf_rom1a0", rd_data, tag(1, 0, 0));

        // clr with simultaneous ROM0 write
        idle();
        clr = 1'b1; wc[0] = 2'd1; din[0] = 64'hDEAD_BEEF_0000_0002;
        tick();
        idle();
        chk("clr_load_done", {63'h0, load_done}, 64'h0);
        chk("clr_wr_err", {63'h0, wr_err}, 64'h0);
        rd(0, 0, 0);
        chk("clr_discard", rd_data, tag(0, 0, 0));
        wr1(0, 2'd1, 64'h0000_0000_C0FF_EE00);
        rd(0, 1, 0);  // rd_seg ignored for ROM0
        chk("clr_wptr0", rd_data, 64'h0000_0000_C0FF_EE00);
        rd(0, 0, 1);
        chk("clr_entry1", rd_data, tag(0, 0, 1));
        chk("clr_no_err", {63'h0, wr_err}, 64'h0);

        // Illegal code
        wr1(4, 2'd3, 64'hBAD0_BAD0_BAD0_BAD0);
        chk("ill_wr_err", {63'h0, wr_err}, 64'h1);
        wr1(4, 2'd2, 64'h0000_0000_0000_4B00);
        rd(4, 1, 0);
        chk("ill_b_ptr", rd_data, 64'h0000_0000_0000_4B00);
        rd(4, 1, 1);
        chk("ill_b_e1", rd_data, tag(4, 1, 1));
        rd(4, 0, 0);
        chk("ill_a_e0", rd_data, tag(4, 0, 0));

        // Collision on ROM2.B entry 5
        idle(); clr = 1'b1; tick(); idle();
        for (int i = 0; i < 6; i++) wr1(2, 2'd2, 64'h55);
        idle(); clr = 1'b1; tick(); idle();
        for (int i = 0; i < 5; i++) wr1(2, 2'd2, 64'h11);
        idle();
        wc[2] = 2'd2; din[2] = 64'hAA;
        rd_en = 1'b1; rd_rom = 3'd2; rd_seg = 1'b1; rd_addr = 4'd5;
        tick();
        idle();
        chk("col_old", rd_data, 64'h55);
        rd(2, 1, 5);
        chk("col_new", rd_data, 64'hAA);
        rd(2, 1, 4);
        chk("col_e4", rd_data, 64'h11);

        // Refill after clr completes normally
        idle(); clr = 1'b1; tick(); idle();
        chk("refill_ld0", {63'h0, load_done}, 64'h0);
        run_windows(4);
        tick();
        chk("refill_load_done", {63'h0, load_done}, 64'h1);
        chk("refill_wr_err", {63'h0, wr_err}, 64'h0);
        read_all("refill");

        // Asynchronous reset mid-cycle
        rd(3, 1, 9);
        chk("pre_rst_data", rd_data, tag(3, 1, 9));
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_data", rd_data, 64'h0);
        chk("arst_rd_valid", {63'h0, rd_valid}, 64'h0);
        chk("arst_load_done", {63'h0, load_done}, 64'h0);
        chk("arst_wr_err", {63'h0, wr_err}, 64'h0);
        tick();
        rst = 1'b0;
        wr1(0, 2'd1, 64'h0000_0000_0000_0777);
        rd(0, 0, 0);
        chk("arst_wptr0", rd_data, 64'h0000_0000_0000_0777);
        rd(0, 0, 1);
        chk("arst_stale", rd_data, tag(0, 0, 1));
        chk("arst_ld_after", {63'h0, load_done}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
